// File: rtl/ahb_arbiter.sv
// Round-robin arbiter for four AHB masters: re-arbitrates on Hready, caps tenure at MAX_TENURE beats.
// Define AHB_ARB_LOCK_EN to honour Hlock_n locked sequences; without it Hlock_n is ignored.
module ahb_arbiter #(
   parameter int unsigned MAX_TENURE     = 8,
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input  logic       Hclk,
   input  logic       Hreset,
   input  logic       Hbusreq_1,
   input  logic       Hbusreq_2,
   input  logic       Hbusreq_3,
   input  logic       Hbusreq_4,
   input  logic       Hlock_1,
   input  logic       Hlock_2,
   input  logic       Hlock_3,
   input  logic       Hlock_4,
   input  logic [1:0] Htrans,
   input  logic       Hready,
   output logic       Hgrant_1,
   output logic       Hgrant_2,
   output logic       Hgrant_3,
   output logic       Hgrant_4,
   output logic [1:0] Hmaster,
   output logic       Hmastlock
);

   typedef enum logic [1:0] {PARK, OWN, LOCK} arb_state_t;

   localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);
   localparam logic [1:0] DEF_IDX     = 2'(DEFAULT_MASTER);

   arb_state_t state, state_nxt;
   logic [1:0] own, own_nxt;
   logic [1:0] rr_ptr, rr_nxt;
   logic [7:0] tenure, tenure_nxt;
   logic [3:0] grant_q;
   logic [3:0] req;
   logic [1:0] win;
   logic       win_found;
   logic       other_req;
   logic       ap;

   assign req       = {Hbusreq_4, Hbusreq_3, Hbusreq_2, Hbusreq_1};
   assign other_req = |(req & ~(4'b0001 << own));

   assign Hgrant_1 = grant_q[0];
   assign Hgrant_2 = grant_q[1];
   assign Hgrant_3 = grant_q[2];
   assign Hgrant_4 = grant_q[3];

   // Only the transfer-type MSB distinguishes counted beats (NONSEQ/SEQ) from IDLE/BUSY.
   logic unused_htrans;
   assign unused_htrans = Htrans[0];

`ifdef AHB_ARB_LOCK_EN
   logic [3:0] lock;
   assign lock = {Hlock_4, Hlock_3, Hlock_2, Hlock_1};
`else
   logic unused_lock;
   assign unused_lock = ^{Hlock_1, Hlock_2, Hlock_3, Hlock_4};
`endif

   // Scan order starts just past the last winner, so the previous owner ends up last.
   always_comb begin
      win       = rr_ptr;
      win_found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!win_found && req[rr_ptr + 2'(k)]) begin
            win       = rr_ptr + 2'(k);
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt  = state;
      own_nxt    = own;
      rr_nxt     = rr_ptr;
      tenure_nxt = tenure;
      ap         = 1'b0;

      if (Hready) begin
         unique case (state)
            PARK: ap = 1'b1;
            OWN:  ap = !req[own] || (Htrans[1] && tenure == TENURE_LAST && other_req);
            LOCK: begin
`ifdef AHB_ARB_LOCK_EN
               ap = !lock[own];
`endif
            end
            default: ap = 1'b1;
         endcase

         if (ap) begin
            tenure_nxt = '0;
            if (win_found) begin
               own_nxt = win;
               rr_nxt  = win;
`ifdef AHB_ARB_LOCK_EN
               state_nxt = lock[win] ? LOCK : OWN;
`else
               state_nxt = OWN;
`endif
            end else begin
               state_nxt = PARK;
            end
         end else if (state == OWN && Htrans[1] && tenure != TENURE_LAST) begin
            tenure_nxt = tenure + 8'd1;
         end
      end
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state   <= PARK;
         own     <= DEF_IDX;
         rr_ptr  <= DEF_IDX;
         tenure  <= '0;
         grant_q <= 4'b0001 << DEF_IDX;
         Hmaster <= DEF_IDX;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state   <= state_nxt;
         own     <= own_nxt;
         rr_ptr  <= rr_nxt;
         tenure  <= tenure_nxt;
         grant_q <= 4'b0001 << own_nxt;
         if (Hready) begin
            Hmaster <= own;
         end
      end
   end

`ifdef AHB_ARB_LOCK_EN
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         Hmastlock <= 1'b0;
      end else if (Hready) begin
         Hmastlock <= (state == LOCK);
      end
   end
`else
   assign Hmastlock = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: a beat-counting reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ahb_arbiter;

   localparam int MAXT = 4;
   localparam int DEF  = 0;
`ifdef AHB_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       Hclk;
   logic       Hreset;
   logic       Hbusreq_1, Hbusreq_2, Hbusreq_3, Hbusreq_4;
   logic       Hlock_1, Hlock_2, Hlock_3, Hlock_4;
   logic [1:0] Htrans;
   logic       Hready;
   logic       Hgrant_1, Hgrant_2, Hgrant_3, Hgrant_4;
   logic [1:0] Hmaster;
   logic       Hmastlock;
   logic [3:0] g;

   int total = 0;
   int bad   = 0;

   ahb_arbiter #(.MAX_TENURE(MAXT), .DEFAULT_MASTER(DEF)) dut (
      .Hclk(Hclk), .Hreset(Hreset),
      .Hbusreq_1(Hbusreq_1), .Hbusreq_2(Hbusreq_2), .Hbusreq_3(Hbusreq_3), .Hbusreq_4(Hbusreq_4),
      .Hlock_1(Hlock_1), .Hlock_2(Hlock_2), .Hlock_3(Hlock_3), .Hlock_4(Hlock_4),
      .Htrans(Htrans), .Hready(Hready),
      .Hgrant_1(Hgrant_1), .Hgrant_2(Hgrant_2), .Hgrant_3(Hgrant_3), .Hgrant_4(Hgrant_4),
      .Hmaster(Hmaster), .Hmastlock(Hmastlock)
   );

   assign g = {Hgrant_4, Hgrant_3, Hgrant_2, Hgrant_1};

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner, last winner, beats used in this tenure, mode 0=parked 1=owning 2=locked.
   int m_owner, m_last, m_used, m_mode, m_master;
   bit m_mlock;
   bit started = 1'b0;

   always @(posedge Hclk) begin
      bit [3:0] r, lk;
      bit contested, rearb;
      int pick;
      r  = {Hbusreq_4, Hbusreq_3, Hbusreq_2, Hbusreq_1};
      lk = {Hlock_4, Hlock_3, Hlock_2, Hlock_1};
      if (Hreset) begin
         m_owner  = DEF;
         m_last   = DEF;
         m_used   = 0;
         m_mode   = 0;
         m_master = DEF;
         m_mlock  = 1'b0;
         started  = 1'b1;
      end else if (Hready) begin
         contested = 1'b0;
         for (int i = 0; i < 4; i++) if (i != m_owner && r[i]) contested = 1'b1;
         m_master = m_owner;
         m_mlock  = (m_mode == 2);
         rearb = (m_mode == 0)
              || (m_mode == 1 && !r[m_owner])
              || (m_mode == 1 && Htrans[1] && m_used + 1 >= MAXT && contested)
              || (m_mode == 2 && !lk[m_owner]);
         if (rearb) begin
            pick = -1;
            for (int k = 1; k <= 4; k++)
               if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
            m_used = 0;
            if (pick < 0) begin
               m_mode = 0;
            end else begin
               m_owner = pick;
               m_last  = pick;
               m_mode  = (LOCK_EN && lk[pick]) ? 2 : 1;
            end
         end else if (m_mode == 1 && Htrans[1] && m_used < MAXT - 1) begin
            m_used++;
         end
      end
   end

   always @(negedge Hclk) begin
      if (started) begin
         check("model_grant", g, 32'(4'b0001 << m_owner));
         check("model_onehot", 32'($onehot(g)), 1);
         check("model_hmaster", Hmaster, m_master);
         check("model_hmastlock", Hmastlock, m_mlock);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge Hclk);
   endtask

   task automatic set_req(input logic [3:0] r);
      {Hbusreq_4, Hbusreq_3, Hbusreq_2, Hbusreq_1} = r;
   endtask

   initial begin
      Hreset = 1'b1;
      set_req(4'b0000);
      {Hlock_4, Hlock_3, Hlock_2, Hlock_1} = 4'b0000;
      Htrans = 2'b00;
      Hready = 1'b1;
      step(3);

      // Idle after reset: parked on default master.
      Hreset = 1'b0;
      step(10);
      check("reset_grant", g, 4'b0001);
      check("reset_hmaster", Hmaster, 0);
      check("reset_hmastlock", Hmastlock, 0);

      // Single requester 3, then release: grant parks on 3.
      set_req(4'b0100);
      step(1);
      check("req3_grant", g, 4'b0100);
      check("req3_hmaster_lag", Hmaster, 0);
      step(1);
      check("req3_hmaster", Hmaster, 2);
      set_req(4'b0000);
      step(1);
      check("park3_grant", g, 4'b0100);
      check("park3_hmaster", Hmaster, 2);
      step(2);
      check("park3_hold", g, 4'b0100);

      // Everyone requesting NONSEQ: rotation every MAXT beats, starting after master 3.
      set_req(4'b1111);
      Htrans = 2'b10;
      step(1);
      check("rot_m4", g, 4'b1000);
      step(3);
      check("rot_m4_still", g, 4'b1000);
      step(1);
      check("rot_m1", g, 4'b0001);
      step(4);
      check("rot_m2", g, 4'b0010);

      // Master 2 reaches its limit, then wait states stall the handover to 4.
      set_req(4'b1010);
      step(3);
      check("limit_m2", g, 4'b0010);
      Hready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("wait_hold_grant", g, 4'b0010);
         check("wait_hold_hmaster", Hmaster, 1);
      end
      Hready = 1'b1;
      step(1);
      check("wait_release_m4", g, 4'b1000);
      check("wait_release_hmaster", Hmaster, 1);
      step(1);
      check("wait_release_hmaster2", Hmaster, 3);

      // BUSY beats do not consume tenure; one beat already used above.
      set_req(4'b1001);
      Htrans = 2'b01;
      step(10);
      check("busy_no_handover", g, 4'b1000);
      Htrans = 2'b11;
      step(2);
      check("seq_not_yet", g, 4'b1000);
      step(1);
      check("seq_handover_m1", g, 4'b0001);

      // Owner releases while 3 and 4 request: scan from master 1 reaches 3 first.
      set_req(4'b1100);
      step(1);
      check("release_scan_m3", g, 4'b0100);
      set_req(4'b0000);
      step(2);
      check("idle_park_m3", g, 4'b0100);

      // Reset in the middle of a granted burst.
      set_req(4'b0010);
      Htrans = 2'b10;
      step(1);
      check("pre_reset_m2", g, 4'b0010);
      Hreset = 1'b1;
      step(1);
      check("mid_reset_grant", g, 4'b0001);
      check("mid_reset_hmaster", Hmaster, 0);
      Hreset = 1'b0;
      step(1);
      check("post_reset_m2", g, 4'b0010);
      check("post_reset_hmaster", Hmaster, 0);
      set_req(4'b0000);
      step(2);

`ifdef AHB_ARB_LOCK_EN
      // Locked sequence by master 1 outlasts the tenure limit.
      Hreset = 1'b1;
      step(1);
      Hreset = 1'b0;
      set_req(4'b0001);
      Hlock_1 = 1'b1;
      Htrans  = 2'b10;
      step(1);
      check("lock_grant_m1", g, 4'b0001);
      check("lock_mastlock_lag", Hmastlock, 0);
      set_req(4'b1111);
      step(1);
      check("lock_mastlock", Hmastlock, 1);
      step(20);
      check("lock_held_grant", g, 4'b0001);
      check("lock_held_mastlock", Hmastlock, 1);
      Hlock_1 = 1'b0;
      step(1);
      check("unlock_grant_m2", g, 4'b0010);
      check("unlock_mastlock_lag", Hmastlock, 1);
      step(1);
      check("unlock_mastlock", Hmastlock, 0);
      set_req(4'b0000);
      step(2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin bus arbiter for four AHB masters sharing one address/data path.
- Produces one-hot grants Hgrant_1..Hgrant_4 and a registered Hmaster index, which drives the master-side address mux ahead of the slave-select decode.
- Re-arbitrates only at Hready-qualified boundaries.
- Enforces a maximum transfer tenure so that no single master starves the others.

Parameters:
- MAX_TENURE, 8: number of Hready-qualified active transfers (NONSEQ/SEQ) an owner may issue before a forced handover, if another master is requesting. Legal range 1..255.
- DEFAULT_MASTER, 0: index (0..3) granted out of reset and parked on when the bus is idle from reset.

Ports:
- Hclk  input  1  bus clock; all state updates on rising edge.
- Hreset  input  1  synchronous active-high reset.
- Hbusreq_1..Hbusreq_4  input  1 each  bus request from masters 1..4.
- Hlock_1..Hlock_4  input  1 each  locked-transfer request from masters 1..4.
- Htrans  input  2  transfer type of current owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- Hready  input  1  transfer-complete from the selected slave.
- Hgrant_1..Hgrant_4  output  1 each  one-hot registered grant.
- Hmaster  output  2  index of the master owning the address phase (0 = master 1).
- Hmastlock  output  1  current address phase is a locked sequence.

Behaviour:
- Reset (Hreset=1 at rising edge): Hgrant one-hot at DEFAULT_MASTER; Hmaster=DEFAULT_MASTER; Hmastlock=0; rr_ptr=DEFAULT_MASTER; tenure=0; state=PARK.
  - Reset mid-burst overrides everything, with no completion of the current transfer.
- Registered state: current owner (own), rr_ptr (last winner), tenure counter (8-bit), state in {PARK, OWN, LOCK}.
- Arbitration point (AP): rising edge with Hready=1 and any of the following:
  - state=PARK;
  - state=OWN and Hbusreq_own=0;
  - state=OWN and tenure==MAX_TENURE-1 and the counted cycle is active and some other Hbusreq=1.
  - No AP in state LOCK.
- Winner selection at AP: first asserted Hbusreq scanning (rr_ptr+1), (rr_ptr+2), (rr_ptr+3), rr_ptr, all mod 4.
  - If a winner exists: grant it, rr_ptr<=winner, tenure<=0, state<=OWN (or LOCK, see Optional Feature).
  - If no request is pending: grant is unchanged (park on last owner), state<=PARK, tenure<=0.
- Hready=0: grant, state, rr_ptr and tenure all hold. Requests are sampled only when Hready=1.
- Tenure counter: increments on edges with Hready=1, state=OWN, and Htrans[1]=1 (NONSEQ/SEQ). It saturates at MAX_TENURE-1 and clears on any grant change.
  - IDLE/BUSY beats do not count.
- Forced handover with the owner still requesting: the owner becomes lowest priority through normal rr_ptr rotation. It loses grant even mid-burst; the burst is re-issued by the master per AHB early-termination rules.
- Hmaster/Hmastlock: on each rising edge with Hready=1, Hmaster<=index of the current Hgrant, and Hmastlock<=(state==LOCK).
  - Hmaster therefore lags a grant change by exactly one Hready-qualified cycle.
  - Hready=0 holds both.
- Grant outputs are always exactly one-hot, including through reset, park and wait states.
- Simultaneous request assertion and owner release on the same AP: the new requester wins per the scan order. An owner that deasserts and reasserts in the same cycle is treated as requesting.

Optional Feature:
- Macro AHB_ARB_LOCK_EN.
- Defined:
  - At AP, if the winner's Hlock is 1, state<=LOCK.
  - While in LOCK, the grant is held regardless of tenure and other requests.
  - Exit: edge with Hready=1 and Hlock_own=0. This is treated as an AP with the normal scan, and rr_ptr is unchanged by the lock.
  - Hmastlock follows the Hmaster timing rule.
- Not defined:
  - Hlock_1..4 are ignored and LOCK is unreachable.
  - Hmastlock is tied to 0.
  - Ports remain present.

Test Plan:
- Reset with DEFAULT_MASTER=0, no requests, 10 cycles -> Hgrant_1=1, Hgrant_2..4=0, Hmaster=0, Hmastlock=0 throughout.
- Hbusreq_3=1 alone, Hready=1 -> Hgrant_3=1 on next edge; Hmaster=2 one edge later; Hbusreq_3 drops -> grant parks on master 3, Hmaster stays 2.
- All four request continuously, Htrans=NONSEQ every cycle, MAX_TENURE=4, Hready=1 -> grant rotates 1→2→3→4→1, each owner holding exactly 4 counted cycles.
- Owner 2 granted, Hbusreq_4=1, Hready=0 for 5 cycles at tenure limit -> no grant change until the first Hready=1 edge, then Hgrant_4=1.
- Htrans=BUSY for 10 cycles with MAX_TENURE=2 and competitor requesting -> no handover, since BUSY beats do not count; handover follows 2 NONSEQ/SEQ beats.
- AHB_ARB_LOCK_EN defined: master 1 wins with Hlock_1=1, competitors request, 20 NONSEQ beats, MAX_TENURE=4 -> Hgrant_1 held and Hmastlock=1; Hlock_1=0 with Hready=1 -> Hgrant_2=1 next edge, Hmastlock=0 one edge later.
